multi_stream_synchronizer_v2: RTL



---
 rtl/multi_stream_synchronizer_v2_if.sv | 44 ++++
 rtl/multi_stream_synchronizer_v2.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multi_stream_synchronizer_v2_if.sv
// rtl/multi_stream_synchronizer_v2_if.sv - write/read control bundle for the multi-stream synchronizer
interface multi_stream_synchronizer_v2_if #(
    parameter int DEPTH_LOG2  = 9,
    parameter int NUM_STREAMS = 20
);
    logic [NUM_STREAMS-1:0]            writes;
    logic [DEPTH_LOG2*NUM_STREAMS-1:0] writeAddrs;
    logic [NUM_STREAMS-1:0]            writeAccepted;
    logic [NUM_STREAMS-1:0]            almostFulls;
    logic [NUM_STREAMS-1:0]            overflow;
    logic                              flush;
    logic                              slowDown;
    logic                              readEnable;
    logic [DEPTH_LOG2-1:0]             readAddr;
    logic                              readsPending;

    // Producer/consumer side: drives write strobes and read-flow controls.
    modport master (
        output writes,
        output flush,
        output slowDown,
        input  writeAddrs,
        input  writeAccepted,
        input  almostFulls,
        input  overflow,
        input  readEnable,
        input  readAddr,
        input  readsPending
    );

    // Synchronizer side: owns all pointers and read strobes.
    modport slave (
        input  writes,
        input  flush,
        input  slowDown,
        output writeAddrs,
        output writeAccepted,
        output almostFulls,
        output overflow,
        output readEnable,
        output readAddr,
        output readsPending
    );
endinterface

// File: rtl/multi_stream_synchronizer_v2.sv
// rtl/multi_stream_synchronizer_v2.sv - shared-read-pointer address generator for NUM_STREAMS write streams
module multi_stream_synchronizer_v2 #(
    parameter int DEPTH_LOG2         = 9,
    parameter int NUM_STREAMS        = 20,
    parameter int ALMOST_FULL_MARGIN = 16,
    parameter int READ_PERIOD        = 3,
    parameter int READ_PIPE          = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    multi_stream_synchronizer_v2_if.slave bus
);
    localparam int CNT_W = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2-1:0] AF_MARGIN = DEPTH_LOG2'(ALMOST_FULL_MARGIN);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(READ_PERIOD - 1);

    logic [DEPTH_LOG2-1:0] wr_addr_q [NUM_STREAMS];
    logic [DEPTH_LOG2-1:0] wr_addr_d [NUM_STREAMS];
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_d;
    logic [NUM_STREAMS-1:0] has_data_q;
    logic [NUM_STREAMS-1:0] has_data_d;
    logic [NUM_STREAMS-1:0] almost_full_q;
    logic [NUM_STREAMS-1:0] almost_full_d;
    logic [NUM_STREAMS-1:0] overflow_q;
    logic [NUM_STREAMS-1:0] overflow_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [READ_PIPE-1:0]   pipe_valid_q;
    logic [READ_PIPE-1:0]   pipe_valid_d;
    logic [DEPTH_LOG2-1:0]  pipe_addr_q [READ_PIPE];
    logic [DEPTH_LOG2-1:0]  pipe_addr_d [READ_PIPE];

    logic [DEPTH_LOG2-1:0]  free_slots [NUM_STREAMS];
    logic [NUM_STREAMS-1:0] full;
    logic [NUM_STREAMS-1:0] accepted;
    logic                   issue;

    // Free space per stream with one slot kept empty; full when nothing is free.
    always_comb begin
        full     = '0;
        accepted = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            free_slots[i] = rd_ptr_q - wr_addr_q[i] - PTR_ONE;
            full[i]       = (free_slots[i] == '0);
            accepted[i]   = bus.writes[i] && !full[i] && !bus.flush;
        end
    end

    // A read goes out only on the cadence slot, when allowed, and when every stream holds an element.
    always_comb begin
        issue    = (cnt_q == '0) && !bus.slowDown && !bus.flush && (&has_data_q);
        rd_ptr_d = issue ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    end

    // Per-stream pointer, occupancy, almost-full and sticky overflow next state.
    always_comb begin
        wr_addr_d     = wr_addr_q;
        has_data_d    = '0;
        almost_full_d = '0;
        overflow_d    = overflow_q;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            if (bus.flush) begin
                wr_addr_d[i] = rd_ptr_q;
            end else if (accepted[i]) begin
                wr_addr_d[i] = wr_addr_q[i] + PTR_ONE;
            end
            // Compare against the post-issue read pointer so back-to-back reads never overrun.
            has_data_d[i]    = !bus.flush && ((wr_addr_q[i] - rd_ptr_d) != '0);
            almost_full_d[i] = (free_slots[i] < AF_MARGIN);
            if (bus.writes[i] && full[i] && !bus.flush) begin
                overflow_d[i] = 1'b1;
            end
        end
    end

    // Free-running cadence counter 0..READ_PERIOD-1.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : (cnt_q + CNT_ONE);
    end

    // Read pipe: addresses only advance alongside a valid so readAddr holds between reads.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_addr_d     = pipe_addr_q;
        pipe_valid_d[0] = issue;
        if (issue) begin
            pipe_addr_d[0] = rd_ptr_q;
        end
        for (int k = 1; k < READ_PIPE; k++) begin
            pipe_valid_d[k] = pipe_valid_q[k-1];
            if (pipe_valid_q[k-1]) begin
                pipe_addr_d[k] = pipe_addr_q[k-1];
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                wr_addr_q[i] <= '0;
            end
            for (int k = 0; k < READ_PIPE; k++) begin
                pipe_addr_q[k] <= '0;
            end
            rd_ptr_q      <= '0;
            has_data_q    <= '0;
            almost_full_q <= '0;
            overflow_q    <= '0;
            cnt_q         <= '0;
            pipe_valid_q  <= '0;
        end else begin
            wr_addr_q     <= wr_addr_d;
            pipe_addr_q   <= pipe_addr_d;
            rd_ptr_q      <= rd_ptr_d;
            has_data_q    <= has_data_d;
            almost_full_q <= almost_full_d;
            overflow_q    <= overflow_d;
            cnt_q         <= cnt_d;
            pipe_valid_q  <= pipe_valid_d;
        end
    end

    // Flatten per-stream write addresses onto the shared bus.
    always_comb begin
        bus.writeAddrs = '0;
        for (int i = 0; i < NUM_STREAMS; i++) begin
            bus.writeAddrs[i*DEPTH_LOG2 +: DEPTH_LOG2] = wr_addr_q[i];
        end
    end

    assign bus.writeAccepted = accepted;
    assign bus.almostFulls   = almost_full_q;
    assign bus.overflow      = overflow_q;
    assign bus.readEnable    = pipe_valid_q[READ_PIPE-1];
    assign bus.readAddr      = pipe_addr_q[READ_PIPE-1];
    assign bus.readsPending  = |pipe_valid_q;
endmodule
